// File: rtl/wait_event_monitor.sv
// Wait engine: watches one synchronized bit of wait_signals for an edge or level
// condition, with optional cycle timeout and abort, and reports the elapsed count.
module wait_event_monitor #(
  parameter int WAIT_SIZE     = 5,
  parameter int TIMEOUT_WIDTH = 32,
  parameter int SEL_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WAIT_SIZE-1:0]     wait_signals,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [SEL_WIDTH-1:0]     cmd_sel,
  input  logic [1:0]               cmd_mode,
  input  logic [TIMEOUT_WIDTH-1:0] cmd_timeout,
  input  logic                     cmd_abort,
  output logic                     busy,
  output logic                     done,
  output logic                     hit,
  output logic                     timeout,
  output logic                     err,
  output logic [TIMEOUT_WIDTH-1:0] elapsed
);

  localparam int                       SEL_SPAN     = 1 << SEL_WIDTH;
  localparam logic [SEL_WIDTH:0]       WAIT_SIZE_W  = (SEL_WIDTH+1)'(WAIT_SIZE);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE      = TIMEOUT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ZERO     = '0;
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ALL_ONES = '1;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_HIGH = 2'b10;
  localparam logic [1:0] MODE_LOW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARM  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t                   state_reg, state_next;
  logic [WAIT_SIZE-1:0]     meta_reg;
  logic [WAIT_SIZE-1:0]     sync_reg;
  logic [SEL_WIDTH-1:0]     sel_reg, sel_next;
  logic [1:0]               mode_reg, mode_next;
  logic [TIMEOUT_WIDTH-1:0] tmo_reg, tmo_next;
  logic                     prev_reg, prev_next;
  logic [TIMEOUT_WIDTH-1:0] elapsed_reg, elapsed_next;
  logic                     hit_reg, hit_next;
  logic                     timeout_reg, timeout_next;
  logic                     err_reg, err_next;

  logic [SEL_SPAN-1:0]      sync_pad;
  logic                     s;
  logic                     sel_oob;
  logic                     cond_met;
  logic                     tmo_expire;

  // Two-flop synchronizer for every watchable input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= wait_signals;
      sync_reg <= meta_reg;
    end
  end

  // Pad the synchronized bus to the full select range so unused slots read 0.
  genvar gi;
  generate
    for (gi = 0; gi < SEL_SPAN; gi++) begin : g_pad
      if (gi < WAIT_SIZE) begin : g_slot
        assign sync_pad[gi] = sync_reg[gi];
      end else begin : g_empty
        assign sync_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign s       = sync_pad[sel_reg];
  assign sel_oob = ({1'b0, cmd_sel} >= WAIT_SIZE_W);

  always_comb begin
    cond_met = 1'b0;
    case (mode_reg)
      MODE_RISE: cond_met = s & ~prev_reg;
      MODE_FALL: cond_met = ~s & prev_reg;
      MODE_HIGH: cond_met = s;
      MODE_LOW:  cond_met = ~s;
      default:   cond_met = 1'b0;
    endcase
  end

  assign tmo_expire = (tmo_reg != TMO_ZERO) && (elapsed_reg == (tmo_reg - TMO_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      sel_reg     <= '0;
      mode_reg    <= '0;
      tmo_reg     <= '0;
      prev_reg    <= 1'b0;
      elapsed_reg <= '0;
      hit_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      mode_reg    <= mode_next;
      tmo_reg     <= tmo_next;
      prev_reg    <= prev_next;
      elapsed_reg <= elapsed_next;
      hit_reg     <= hit_next;
      timeout_reg <= timeout_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    mode_next    = mode_reg;
    tmo_next     = tmo_reg;
    prev_next    = prev_reg;
    elapsed_next = elapsed_reg;
    hit_next     = hit_reg;
    timeout_next = timeout_reg;
    err_next     = err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          sel_next     = cmd_sel;
          mode_next    = cmd_mode;
          tmo_next     = cmd_timeout;
          hit_next     = 1'b0;
          timeout_next = 1'b0;
          elapsed_next = '0;
          if (sel_oob) begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end else begin
            err_next   = 1'b0;
            state_next = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        // Sampling prev here means an edge present before arming never counts.
        prev_next  = s;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        prev_next = s;
        if (cmd_abort) begin
          state_next = ST_DONE;
        end else if (cond_met) begin
          hit_next   = 1'b1;
          state_next = ST_DONE;
        end else if (tmo_expire) begin
          timeout_next = 1'b1;
          elapsed_next = tmo_reg;
          state_next   = ST_DONE;
        end else if (elapsed_reg != TMO_ALL_ONES) begin
          elapsed_next = elapsed_reg + TMO_ONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_ARM) || (state_reg == ST_WAIT);
  assign done      = (state_reg == ST_DONE);
  assign hit       = hit_reg;
  assign timeout   = timeout_reg;
  assign err       = err_reg;
  assign elapsed   = elapsed_reg;

endmodule

// File: tb/tb_wait_event_monitor.sv
// Directed bench for wait_event_monitor: reset, edge/level hits, timeout,
// abort, hit-vs-timeout priority, select error and mid-wait reset.
module tb_wait_event_monitor;

  localparam int WS = 5;
  localparam int TW = 32;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WS-1:0] wait_signals = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [SW-1:0] cmd_sel = '0;
  logic [1:0]    cmd_mode = '0;
  logic [TW-1:0] cmd_timeout = '0;
  logic          cmd_abort = 1'b0;
  logic          busy;
  logic          done;
  logic          hit;
  logic          timeout;
  logic          err;
  logic [TW-1:0] elapsed;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  int base_cnt = 0;

  wait_event_monitor #(
    .WAIT_SIZE    (WS),
    .TIMEOUT_WIDTH(TW),
    .SEL_WIDTH    (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wait_signals(wait_signals),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_sel     (cmd_sel),
    .cmd_mode    (cmd_mode),
    .cmd_timeout (cmd_timeout),
    .cmd_abort   (cmd_abort),
    .busy        (busy),
    .done        (done),
    .hit         (hit),
    .timeout     (timeout),
    .err         (err),
    .elapsed     (elapsed)
  );

  always #5 clk = ~clk;

  // The cycle number of a cycle is the value cyc holds during it.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Returns at #1 after the accept edge, i.e. in cycle T+1.
  task automatic issue(input string tag, input logic [SW-1:0] sel, input logic [1:0] mode,
                       input logic [TW-1:0] tmo);
    @(posedge clk);
    #1;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    base_cnt    = done_cnt;
    cmd_sel     = sel;
    cmd_mode    = mode;
    cmd_timeout = tmo;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && done_cnt == base_cnt; i++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_done"}, 32'(done_cnt - base_cnt), 32'd1);
  endtask

  // Latency in cycles from the accept cycle T to the done cycle.
  function automatic int lat();
    return done_cyc - acc_cyc + 1;
  endfunction

  initial begin
    wait_signals[2] = 1'b1;
    wait_signals[3] = 1'b1;

    // Reset held with a pending command.
    cmd_valid = 1'b1;
    cmd_sel   = 3'd2;
    cmd_mode  = 2'b10;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_elapsed", elapsed, 32'd0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy_after", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);

    // Rising edge on bit 0, 20 cycles after accept.
    issue("rise", 3'd0, 2'b00, 32'd100);
    chk("rise_busy", 32'(busy), 32'd1);
    repeat (19) @(posedge clk);
    #1;
    wait_signals[0] = 1'b1;
    wait_done("rise", 20);
    chk("rise_hit", 32'(hit), 32'd1);
    chk("rise_timeout", 32'(timeout), 32'd0);
    chk("rise_elapsed", elapsed, 32'd20);
    chk("rise_lat", 32'(lat()), 32'd23);
    repeat (5) @(negedge clk);
    chk("rise_once", 32'(done_cnt - base_cnt), 32'd1);
    chk("rise_hold_hit", 32'(hit), 32'd1);

    // High level already present before arming is not a rising edge.
    issue("prearm", 3'd0, 2'b00, 32'd10);
    wait_done("prearm", 30);
    chk("prearm_hit", 32'(hit), 32'd0);
    chk("prearm_timeout", 32'(timeout), 32'd1);
    chk("prearm_elapsed", elapsed, 32'd10);
    chk("prearm_lat", 32'(lat()), 32'd12);
    wait_signals[0] = 1'b0;

    // Level high already satisfied: earliest completion.
    issue("level", 3'd2, 2'b10, 32'd0);
    wait_done("level", 10);
    chk("level_hit", 32'(hit), 32'd1);
    chk("level_elapsed", elapsed, 32'd0);
    chk("level_lat", 32'(lat()), 32'd3);

    // Falling edge on a static low signal: timeout after 16 cycles.
    issue("tmo", 3'd1, 2'b01, 32'd16);
    wait_done("tmo", 30);
    chk("tmo_timeout", 32'(timeout), 32'd1);
    chk("tmo_hit", 32'(hit), 32'd0);
    chk("tmo_elapsed", elapsed, 32'd16);
    chk("tmo_lat", 32'(lat()), 32'd18);

    // No timeout: only an abort ends the wait.
    issue("abort", 3'd1, 2'b01, 32'd0);
    repeat (1000) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(done_cnt - base_cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    cmd_abort = 1'b1;
    @(posedge clk);
    #1;
    cmd_abort = 1'b0;
    wait_done("abort", 5);
    chk("abort_hit", 32'(hit), 32'd0);
    chk("abort_timeout", 32'(timeout), 32'd0);
    chk("abort_elapsed", elapsed, 32'd999);

    // Falling edge lands in the same WAIT cycle as timeout expiry: hit wins.
    issue("race", 3'd3, 2'b01, 32'd10);
    repeat (8) @(posedge clk);
    #1;
    wait_signals[3] = 1'b0;
    wait_done("race", 20);
    chk("race_hit", 32'(hit), 32'd1);
    chk("race_timeout", 32'(timeout), 32'd0);
    chk("race_elapsed", elapsed, 32'd9);
    chk("race_lat", 32'(lat()), 32'd12);

    // Out-of-range select.
    issue("err", 3'd5, 2'b00, 32'd10);
    wait_done("err", 5);
    chk("err_flag", 32'(err), 32'd1);
    chk("err_hit", 32'(hit), 32'd0);
    chk("err_elapsed", elapsed, 32'd0);
    chk("err_lat", 32'(lat()), 32'd1);

    // Reset in the middle of a wait discards the command.
    issue("midrst", 3'd0, 2'b00, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_nodone", 32'(done_cnt - base_cnt), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);

    issue("after", 3'd2, 2'b10, 32'd5);
    wait_done("after", 10);
    chk("after_hit", 32'(hit), 32'd1);
    chk("after_lat", 32'(lat()), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
